// File: rtl/rounding_scheduler_pkg.sv
// rounding_pkg: shared helpers for rounding_scheduler.
//   MAX_W            widest intermediate the helpers operate on
//   id_width()       width of a requester index (at least 1 bit)
//   round_half_even  round-half-to-even of a pre-extended sample by d bits
//   sat_max/sat_min  saturation limits for a w-bit result, MAX_W-bit extended
package rounding_pkg;

  localparam int MAX_W = 64;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // din must already be sign- or zero-extended to MAX_W bits. The result is
  // the truncated value plus the rounding increment, still MAX_W bits wide,
  // so the caller sees the carry/overflow bit just above its output width.
  function automatic logic [MAX_W-1:0] round_half_even(
    input logic [MAX_W-1:0] din,
    input int               d,
    input bit               is_signed
  );
    logic signed [MAX_W-1:0] s;
    logic [MAX_W-1:0]        trunc;
    logic [MAX_W-1:0]        frac;
    logic [MAX_W-1:0]        half;
    logic                    inc;
    if (d <= 0) return din;
    if (is_signed) begin
      // Arithmetic shift gives floor() for negative samples.
      s     = $signed(din);
      s     = s >>> d;
      trunc = s;
    end else begin
      trunc = din >> d;
    end
    frac = din & ~({MAX_W{1'b1}} << d);
    half = {{(MAX_W-1){1'b0}}, 1'b1} << (d - 1);
    inc  = (frac > half) || ((frac == half) && trunc[0]);
    return trunc + {{(MAX_W-1){1'b0}}, inc};
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(input int w, input bit is_signed);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < (is_signed ? w - 1 : w)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int w, input bit is_signed);
    logic [MAX_W-1:0] r;
    r = '0;
    if (is_signed) begin
      for (int i = 0; i < MAX_W; i++) begin
        if (i >= w - 1) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rounding_scheduler_if.sv
// rounding_scheduler_if: requester and result channels of rounding_scheduler.
//   req_valid/req_data/req_ready  N_REQ input channels (one-hot ready = grant)
//   out_valid/out_ready           result channel
//   out_data/out_id/out_sat       rounded value, source index, saturation flag
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A valid source holds its payload until that edge; ready may depend
// combinationally on the sink's state, valid never waits on ready.
// master = requesters + downstream consumer, slave = the scheduler.
interface rounding_scheduler_if
  import rounding_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH_IN  = 19,
  parameter int WIDTH_OUT = 16
);
  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0][WIDTH_IN-1:0]  req_data;
  logic [N_REQ-1:0]                req_ready;
  logic                            out_valid;
  logic                            out_ready;
  logic [WIDTH_OUT-1:0]            out_data;
  logic [ID_W-1:0]                 out_id;
  logic                            out_sat;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_sat
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, out_sat
  );
endinterface

// File: rtl/rounding_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin arbiter owning the priority pointer.
//   clk, rst  clock, synchronous active-high reset
//   req       request vector
//   en        arbitration allowed this cycle; gnt is zero when low
//   gnt       one-hot grant
//   gnt_idx   encoded grant index
// The search starts at ptr+1 and wraps; ptr moves to the winner only when a
// grant is issued (a grant always implies a transfer, since it is only given
// to an asserted request). Reset leaves ptr at N-1 so index 0 wins first.
module rr_arbiter
  import rounding_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      cand = IW'(idx);
      if (!found && en && req[cand]) begin
        found         = 1'b1;
        gnt[cand]     = 1'b1;
        gnt_idx       = cand;
      end
    end
    ptr_d = found ? gnt_idx : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IW'(N - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rounding_scheduler.sv
// rounding_scheduler: N_REQ requesters share one round-half-to-even rounding
// and saturation stage, WIDTH_IN -> WIDTH_OUT bits.
//   clk, rst  clock, synchronous active-high reset
//   bus       rounding_scheduler_if.slave: requester channels and result
//   sat_clr   clear all saturation counters (wins over an increment)
//   sat_cnt   per-requester count of accepted saturated results (sticks at max)
// Pipeline: S1 captures the granted sample and its ID, S2 holds the rounded
// result and drives out_*. Both stages advance when their successor can take
// data, so full rate runs without bubbles and a stalled S2 freezes out_*.
module rounding_scheduler
  import rounding_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH_IN  = 19,
  parameter int WIDTH_OUT = 16,
  parameter bit IS_SIGNED = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  rounding_scheduler_if.slave         bus,
  input  logic                        sat_clr,
  output logic [N_REQ-1:0][CNT_W-1:0] sat_cnt
);

  localparam int D    = WIDTH_IN - WIDTH_OUT;
  localparam int ID_W = id_width(N_REQ);

  logic                        s1_valid_q, s1_valid_d;
  logic [WIDTH_IN-1:0]         s1_data_q,  s1_data_d;
  logic [ID_W-1:0]             s1_id_q,    s1_id_d;
  logic                        out_valid_q, out_valid_d;
  logic [WIDTH_OUT-1:0]        out_data_q,  out_data_d;
  logic [ID_W-1:0]             out_id_q,    out_id_d;
  logic                        out_sat_q,   out_sat_d;
  logic [N_REQ-1:0][CNT_W-1:0] sat_cnt_q,   sat_cnt_d;

  logic                        s1_adv;
  logic                        s2_adv;
  logic                        arb_en;
  logic [N_REQ-1:0]            gnt;
  logic [ID_W-1:0]             gnt_idx;
  logic [MAX_W-1:0]            din_ext;
  logic [WIDTH_OUT:0]          rnd;
  logic [WIDTH_OUT-1:0]        res;
  logic                        res_sat;
  logic                        out_xfer;

  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  // Holding the grant off during reset keeps req_ready low while rst is high.
  assign arb_en   = s1_adv && !rst;
  assign out_xfer = out_valid_q && bus.out_ready;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_sat   = out_sat_q;
  assign sat_cnt       = sat_cnt_q;

  // Rounding of the S1 sample. The result is kept one bit wider than the
  // output so the increment's carry (unsigned) or sign flip (signed) shows up.
  always_comb begin
    if (IS_SIGNED) din_ext = {{(MAX_W-WIDTH_IN){s1_data_q[WIDTH_IN-1]}}, s1_data_q};
    else           din_ext = {{(MAX_W-WIDTH_IN){1'b0}}, s1_data_q};
    rnd     = (WIDTH_OUT+1)'(round_half_even(din_ext, D, IS_SIGNED));
    res     = rnd[WIDTH_OUT-1:0];
    res_sat = 1'b0;
    if (D > 0) begin
      // Only a +1 can overflow, so the positive limit is the only clamp.
      if (IS_SIGNED) res_sat = rnd[WIDTH_OUT] ^ rnd[WIDTH_OUT-1];
      else           res_sat = rnd[WIDTH_OUT];
      if (res_sat) res = WIDTH_OUT'(sat_max(WIDTH_OUT, IS_SIGNED));
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_id_d     = s1_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_sat_d   = out_sat_q;
    sat_cnt_d   = sat_cnt_q;

    if (s1_adv) begin
      s1_valid_d = |gnt;
      if (|gnt) begin
        s1_data_d = bus.req_data[gnt_idx];
        s1_id_d   = gnt_idx;
      end
    end

    // An empty S1 only drops out_valid; the last payload stays on out_data.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = res;
        out_id_d   = s1_id_q;
        out_sat_d  = res_sat;
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (sat_clr) begin
        sat_cnt_d[i] = '0;
      end else if (out_xfer && out_sat_q && (out_id_q == ID_W'(i)) &&
                   (sat_cnt_q[i] != {CNT_W{1'b1}})) begin
        sat_cnt_d[i] = sat_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_sat_q   <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_id_q     <= s1_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_sat_q   <= out_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

endmodule

// File: tb/tb_rounding_scheduler.sv
// tb_rounding_scheduler: directed bench for rounding_scheduler.
// Two instances: u_s (signed, defaults) and u_u (unsigned, 2-bit counters so
// the saturating counter edge is reachable in a few samples).
module tb_rounding_scheduler;
  import rounding_pkg::*;

  localparam int N   = 4;
  localparam int WI  = 19;
  localparam int WO  = 16;
  localparam int IDW = 2;
  localparam int EW  = IDW + WO + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic                  sat_clr_s, sat_clr_u;
  logic [N-1:0][15:0]    sat_cnt_s;
  logic [N-1:0][1:0]     sat_cnt_u;

  rounding_scheduler_if #(.N_REQ(N), .WIDTH_IN(WI), .WIDTH_OUT(WO)) bus_s ();
  rounding_scheduler_if #(.N_REQ(N), .WIDTH_IN(WI), .WIDTH_OUT(WO)) bus_u ();

  rounding_scheduler #(.N_REQ(N), .WIDTH_IN(WI), .WIDTH_OUT(WO), .IS_SIGNED(1'b1), .CNT_W(16)) u_s (
    .clk(clk), .rst(rst), .bus(bus_s), .sat_clr(sat_clr_s), .sat_cnt(sat_cnt_s));
  rounding_scheduler #(.N_REQ(N), .WIDTH_IN(WI), .WIDTH_OUT(WO), .IS_SIGNED(1'b0), .CNT_W(2)) u_u (
    .clk(clk), .rst(rst), .bus(bus_u), .sat_clr(sat_clr_u), .sat_cnt(sat_cnt_u));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_s_q[$];
  logic [EW-1:0] exp_u_q[$];
  int            exp_t_s_q[$];
  int            exp_t_u_q[$];
  logic [EW-1:0] e_s, e_u;
  int            t_s, t_u;

  logic [WI-1:0] sdat [N];
  logic [WO-1:0] sexp [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [EW-1:0] mk(input int id, input logic [WO-1:0] d, input logic s);
    return {IDW'(id), d, s};
  endfunction

  // Monitors: pop and compare on every accepted output.
  always @(negedge clk) begin
    if (!rst && bus_s.out_valid === 1'b1 && bus_s.out_ready === 1'b1) begin
      if (exp_s_q.size() == 0) begin
        fail("s_unexpected_output");
      end else begin
        e_s = exp_s_q.pop_front();
        t_s = exp_t_s_q.pop_front();
        chk("s_out{id,data,sat}", 32'({bus_s.out_id, bus_s.out_data, bus_s.out_sat}), 32'(e_s));
        if (t_s >= 0) chk("s_latency_cycle", 32'(cyc), 32'(t_s));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus_u.out_valid === 1'b1 && bus_u.out_ready === 1'b1) begin
      if (exp_u_q.size() == 0) begin
        fail("u_unexpected_output");
      end else begin
        e_u = exp_u_q.pop_front();
        t_u = exp_t_u_q.pop_front();
        chk("u_out{id,data,sat}", 32'({bus_u.out_id, bus_u.out_data, bus_u.out_sat}), 32'(e_u));
        if (t_u >= 0) chk("u_latency_cycle", 32'(cyc), 32'(t_u));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus_s.req_valid = '0;
    bus_u.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_s_q.delete(); exp_t_s_q.delete();
    exp_u_q.delete(); exp_t_u_q.delete();
  endtask

  // Presents one sample from requester id of DUT sel (0=signed, 1=unsigned)
  // and records the expected result once the grant is seen.
  task automatic send(input int sel, input int id, input logic [WI-1:0] d,
                      input logic [WO-1:0] ed, input logic es, input bit timed);
    int n;
    bit got;
    if (sel == 0) begin bus_s.req_valid[id] = 1'b1; bus_s.req_data[id] = d; end
    else          begin bus_u.req_valid[id] = 1'b1; bus_u.req_data[id] = d; end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      got = (sel == 0) ? bus_s.req_ready[id] : bus_u.req_ready[id];
      n++;
    end
    if (!got) begin
      fail("grant_timeout");
    end else if (sel == 0) begin
      exp_s_q.push_back(mk(id, ed, es));
      exp_t_s_q.push_back(timed ? cyc + 2 : -1);
    end else begin
      exp_u_q.push_back(mk(id, ed, es));
      exp_t_u_q.push_back(timed ? cyc + 2 : -1);
    end
    @(posedge clk); #1;
    if (sel == 0) begin bus_s.req_valid[id] = 1'b0; bus_s.req_data[id] = WI'($urandom()); end
    else          begin bus_u.req_valid[id] = 1'b0; bus_u.req_data[id] = WI'($urandom()); end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_s_q.size() != 0 || exp_u_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_s_q.size() != 0 || exp_u_q.size() != 0) begin
      fail("drain_missing_outputs");
      exp_s_q.delete(); exp_t_s_q.delete();
      exp_u_q.delete(); exp_t_u_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // All signed requesters valid from reset. The j-th transfer must come from
  // requester j mod N. out_ready drops for 5 cycles starting at stall_at.
  task automatic stream(input int total, input int stall_at, input bit timed);
    int cnt;
    int k;
    bit stalled;
    logic [31:0] held;
    for (int i = 0; i < N; i++) bus_s.req_data[i] = sdat[i];
    bus_s.req_valid = '1;
    cnt = 0;
    k = 0;
    held = '0;
    while (cnt < total && k < 200) begin
      stalled = (k >= stall_at) && (k < stall_at + 5);
      bus_s.out_ready = !stalled;
      @(negedge clk);
      if (stalled) begin
        if (k == stall_at) begin
          chk("bp_out_valid_at_stall", 32'(bus_s.out_valid), 32'(1));
          held = 32'({bus_s.out_id, bus_s.out_data, bus_s.out_sat});
        end else begin
          chk("bp_out_hold", 32'({bus_s.out_id, bus_s.out_data, bus_s.out_sat}), held);
          chk("bp_req_ready_low", 32'(bus_s.req_ready), 32'(0));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus_s.req_valid[i] && bus_s.req_ready[i]) begin
          exp_s_q.push_back(mk(cnt % N, sexp[cnt % N], 1'b0));
          exp_t_s_q.push_back(timed ? cyc + 2 : -1);
          cnt++;
        end
      end
      @(posedge clk); #1;
      k++;
    end
    bus_s.req_valid = '0;
    bus_s.out_ready = 1'b1;
    if (cnt < total) fail("stream_timeout");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    sat_clr_s = 1'b0;
    sat_clr_u = 1'b0;
    bus_s.req_valid = '1;
    bus_u.req_valid = '1;
    bus_s.req_data = '0;
    bus_u.req_data = '0;
    bus_s.out_ready = 1'b1;
    bus_u.out_ready = 1'b1;
    sdat[0] = 19'd20;      sexp[0] = 16'd2;
    sdat[1] = 19'd28;      sexp[1] = 16'd4;
    sdat[2] = 19'h7FFF4;   sexp[2] = 16'hFFFE;
    sdat[3] = 19'd21;      sexp[3] = 16'd3;

    // Reset state, with every requester asking.
    repeat (3) @(negedge clk);
    chk("rst_req_ready_s", 32'(bus_s.req_ready), 32'(0));
    chk("rst_req_ready_u", 32'(bus_u.req_ready), 32'(0));
    chk("rst_out_valid", 32'(bus_s.out_valid), 32'(0));
    chk("rst_out_data", 32'(bus_s.out_data), 32'(0));
    chk("rst_out_id", 32'(bus_s.out_id), 32'(0));
    chk("rst_out_sat", 32'(bus_s.out_sat), 32'(0));
    chk("rst_sat_cnt_s", 32'(sat_cnt_s[0] | sat_cnt_s[1] | sat_cnt_s[2] | sat_cnt_s[3]), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    bus_s.req_valid = '0;
    bus_u.req_valid = '0;

    // Signed rounding, D=3.
    send(0, 0, 19'd20,    16'd2,      1'b0, 1'b1);
    send(0, 1, 19'd28,    16'd4,      1'b0, 1'b1);
    send(0, 3, 19'h7FFF4, 16'hFFFE,   1'b0, 1'b1);
    send(0, 0, 19'd21,    16'd3,      1'b0, 1'b1);
    send(0, 1, 19'd12,    16'd2,      1'b0, 1'b1);
    send(0, 3, 19'h7FFFF, 16'h0000,   1'b0, 1'b1);
    send(0, 0, 19'h40000, 16'h8000,   1'b0, 1'b1);
    send(0, 2, 19'h3FFFF, 16'h7FFF,   1'b1, 1'b1);
    drain();
    chk("s_sat_cnt2", 32'(sat_cnt_s[2]), 32'(1));
    chk("s_sat_cnt0", 32'(sat_cnt_s[0]), 32'(0));

    // Fairness at full rate, then backpressure.
    do_reset();
    stream(8, 1000, 1'b1);
    drain();
    do_reset();
    stream(12, 4, 1'b0);
    drain();

    // Unsigned rounding and counter edges (CNT_W=2).
    do_reset();
    send(1, 0, 19'h00004, 16'h0000, 1'b0, 1'b1);
    send(1, 0, 19'h0000C, 16'h0002, 1'b0, 1'b1);
    send(1, 0, 19'h7FFFB, 16'hFFFF, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(1, 1, 19'h7FFFF, 16'hFFFF, 1'b1, 1'b1);
    drain();
    chk("u_sat_cnt1_at_max", 32'(sat_cnt_u[1]), 32'(3));
    chk("u_sat_cnt0", 32'(sat_cnt_u[0]), 32'(0));
    send(1, 1, 19'h7FFFF, 16'hFFFF, 1'b1, 1'b1);
    drain();
    chk("u_sat_cnt1_sticks", 32'(sat_cnt_u[1]), 32'(3));
    sat_clr_u = 1'b1;
    @(posedge clk); #1;
    sat_clr_u = 1'b0;
    chk("u_sat_clr_alone", 32'(sat_cnt_u[1]), 32'(0));
    send(1, 1, 19'h7FFFF, 16'hFFFF, 1'b1, 1'b1);
    drain();
    chk("u_sat_cnt1_after_clr", 32'(sat_cnt_u[1]), 32'(1));

    // sat_clr in the same cycle as an accepted saturated result.
    bus_u.out_ready = 1'b0;
    send(1, 1, 19'h7FFFF, 16'hFFFF, 1'b1, 1'b0);
    begin
      int n;
      n = 0;
      while (bus_u.out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (bus_u.out_valid !== 1'b1) fail("u_wait_out_valid");
    end
    @(posedge clk); #1;
    sat_clr_u = 1'b1;
    bus_u.out_ready = 1'b1;
    @(posedge clk); #1;
    sat_clr_u = 1'b0;
    chk("u_sat_clr_wins", 32'(sat_cnt_u[1]), 32'(0));
    drain();

    // Reset with S1 and S2 both full behind a stall.
    do_reset();
    bus_s.out_ready = 1'b0;
    bus_s.req_data[0] = 19'd20;
    bus_s.req_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_out_valid", 32'(bus_s.out_valid), 32'(1));
    chk("pre_rst_req_ready", 32'(bus_s.req_ready), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    bus_s.req_valid = '0;
    @(posedge clk); #1;
    chk("rst_flush_out_valid", 32'(bus_s.out_valid), 32'(0));
    rst = 1'b0;
    bus_s.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", 32'(bus_s.out_valid), 32'(0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/rounding_scheduler.md
# rounding_scheduler

Shares one unbiased-rounding (round-half-to-even) and saturation datapath among `N_REQ` requesters. Each requester has its own valid/ready input channel. Round-robin arbitration picks one sample per cycle. The pipeline rounds it from `WIDTH_IN` to `WIDTH_OUT` bits and returns it on a single valid/ready output tagged with the requester ID. The block sits between multi-channel accumulators/filters and narrower downstream consumers, and keeps per-requester saturation statistics.

## Interface
- `N_REQ`, 4, number of requesters (≥1)
- `WIDTH_IN`, 19, input sample width
- `WIDTH_OUT`, 16, output sample width (≤ `WIDTH_IN`)
- `IS_SIGNED`, 1, 1 = two's-complement, 0 = unsigned
- `CNT_W`, 16, saturation counter width
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  per-requester sample valid
- `req_data`  in  N_REQ×WIDTH_IN  per-requester sample
- `req_ready`  out  N_REQ  one-hot grant; transfer on `req_valid[i] && req_ready[i]`
- `out_valid`  out  1  rounded result valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  WIDTH_OUT  rounded, saturated result
- `out_id`  out  max(1,$clog2(N_REQ))  source requester index
- `out_sat`  out  1  result was saturated
- `sat_clr`  in  1  clear all saturation counters
- `sat_cnt`  out  N_REQ×CNT_W  per-requester saturated-result count

## Operation
- Two register stages: S1 holds the captured sample and ID; S2 holds the rounded result (drives `out_*`).
- Advance rules:
  - `s2_adv = !out_valid || out_ready`
  - `s1_adv = !s1_valid || s2_adv`
- Arbitration:
  - Combinational, only when `s1_adv`.
  - Grant goes to the first asserted `req_valid` searching from `ptr+1` upward, wrapping modulo `N_REQ`.
  - `req_ready` is all-zero when `!s1_adv` or when no request is pending.
  - `ptr` updates to the granted index only on a transfer.
- Rounding, with D = `WIDTH_IN − WIDTH_OUT`:
  - `trunc` = `din[WIDTH_IN-1:D]` (floor for signed); `frac` = `din[D-1:0]`; half = 2^(D−1).
  - Add +1 when `frac > half`, or when `frac == half` and `trunc[0] == 1`.
  - Compute at `WIDTH_OUT+1` bits.
- Saturation:
  - Signed: overflow (top two bits differ) → `{0,1…1}`.
  - Unsigned: carry → all ones.
  - Set `out_sat = 1` in either case.
- D = 0: pure pass-through and `out_sat = 0`.
- `sat_cnt[out_id]` increments on `out_valid && out_ready && out_sat`.
  - Counters saturate at 2^CNT_W − 1 (no wrap).
  - `sat_clr` zeroes all counters and wins over a same-cycle increment.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_id=0`, `out_sat=0`, `sat_cnt=0`, S1 invalid.
  - `ptr = N_REQ−1`, so requester 0 has first priority.
  - `req_ready=0` during reset.
- Latency: a sample accepted in cycle k appears on `out_*` in cycle k+2 with no backpressure. Throughput is one sample per cycle.
- Backpressure: while `out_valid && !out_ready`, the `out_*` signals hold stable. S1 stays full once loaded, and `req_ready` drops the cycle after S1 fills behind a stalled S2.
- Simultaneous accept and output in one cycle is legal; there are no bubbles at full rate.
- Reset mid-operation discards in-flight samples; no result is emitted for them.
- Requester data needs to be stable only in the transfer cycle.

## Structure
- Package `rounding_pkg`:
  - `round_half_even` function, parameterised through its argument widths.
  - MAX/MIN saturation constant helpers.
  - Requester ID width helper.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs `clk`, `rst`, `req`, `en`; outputs one-hot `gnt` and encoded `gnt_idx`.
  - Owns `ptr`.
- The top level holds the pipeline, rounding stage and counters.

## Test plan
- Signed rounding (defaults, D=3), with `out_ready=1`:
  - 20 → 2 (tie, even)
  - 28 → 4 (tie, odd)
  - −12 → −2
  - 21 → 3 (above half)
- 0x3FFFF from req 2 → `out_data=0x7FFF`, `out_sat=1`, `out_id=2`, `sat_cnt[2]=1`.
- Unsigned, `IS_SIGNED=0`: 0x7FFFF → 0xFFFF with `out_sat=1`; 0x00004 → 0 (tie, even).
- Fairness: all 4 requesters valid continuously → `out_id` sequence 0,1,2,3,0…; each output arrives 2 cycles after its grant.
- Backpressure: hold `out_ready=0` for 5 cycles with all requesters valid:
  - `out_data` is stable throughout.
  - `req_ready` is 0 from the second stalled cycle.
  - On release, no sample is lost or duplicated.
- Counter edges:
  - Preload a counter at 2^CNT_W−1, then send a saturating sample → the counter stays put.
  - `sat_clr` in the same cycle as a saturating transfer → the counter reads 0.
  - Assert `rst` with S1 and S2 full → `out_valid=0` next cycle, and nothing is emitted afterwards.
